// File: rtl/prg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prg_loader: turns a PRG file download into a stream of CPU RAM writes.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prg_loader #(
  parameter logic [4:0] PRG_INDEX  = 5'd1,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic [4:0]  dl_index,
  output logic        ram_req,
  input  logic        ram_ack,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic [15:0] load_addr,
  output logic [15:0] end_addr,
  output logic        done,
  output logic        error
);

  localparam int             AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    FLUSH = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t        state_q;
  logic          act_q;
  logic [15:0]   load_addr_q;
  logic [15:0]   end_addr_q;
  logic          done_q;
  logic          error_q;

  logic [15:0]   mem_addr_q [FIFO_DEPTH];
  logic [7:0]    mem_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_in_range;
  logic          w_push;
  logic          w_drop;
  logic [24:0]   w_offset;
  logic [24:0]   w_room;
  logic [15:0]   w_wr_addr;
  logic [15:0]   w_head_addr;

  assign w_empty     = (count_q == '0);
  assign w_full      = (count_q == FULL_CNT);
  assign w_pop       = !w_empty && ram_ack;
  assign w_head_addr = mem_addr_q[rd_ptr_q];

  // An offset below 2 underflows to a huge value and is rejected as out of range.
  assign w_offset    = dl_addr - 25'd2;
  assign w_room      = {9'd0, 16'hFFFF - load_addr_q};
  assign w_in_range  = (w_offset <= w_room);
  assign w_wr_addr   = load_addr_q + w_offset[15:0];

  assign w_push_req  = (state_q == DATA) && dl_wr;
  assign w_push      = w_push_req && w_in_range && (!w_full || w_pop);
  assign w_drop      = w_push_req && !w_push;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_addr_q[wr_ptr_q] <= w_wr_addr;
      mem_data_q[wr_ptr_q] <= dl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      act_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      load_addr_q <= 16'h0000;
      end_addr_q  <= 16'h0000;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      act_q   <= dl_active;
      done_q  <= 1'b0;
      count_q <= count_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        end_addr_q <= w_head_addr + 16'd1;
      end
      if (w_drop) begin
        error_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (dl_active && !act_q && (dl_index == PRG_INDEX)) begin
            state_q     <= HDR;
            error_q     <= 1'b0;
            load_addr_q <= 16'h0000;
            end_addr_q  <= 16'h0000;
          end
        end
        HDR: begin
          if (!dl_active) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (dl_wr) begin
            if (dl_addr == 25'd0) begin
              load_addr_q[7:0] <= dl_data;
            end else if (dl_addr == 25'd1) begin
              load_addr_q[15:8] <= dl_data;
              state_q           <= DATA;
            end
          end
        end
        DATA: begin
          if (!dl_active) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // done is raised together with entry into FIN so it lasts exactly that cycle.
          if (w_empty) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ram_req   = !w_empty;
  assign ram_addr  = w_empty ? 16'h0000 : w_head_addr;
  assign ram_data  = w_empty ? 8'h00 : mem_data_q[rd_ptr_q];
  assign load_addr = load_addr_q;
  assign end_addr  = end_addr_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_prg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prg_loader: randomized and directed check of prg_loader.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_prg_loader;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_HDR = 1, P_DATA = 2, P_FLUSH = 3, P_FIN = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [4:0]  dl_index;
  logic        ram_req;
  logic        ram_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic [15:0] load_addr;
  logic [15:0] end_addr;
  logic        done;
  logic        error;

  prg_loader #(.PRG_INDEX(5'd1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_index(dl_index),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_addr(ram_addr),
    .ram_data(ram_data), .load_addr(load_addr), .end_addr(end_addr),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending writes as a queue of {addr, data}
  logic [23:0] m_q[$];
  int          m_phase;
  bit          m_prev;
  logic [15:0] m_load;
  logic [15:0] m_end;
  bit          m_err;

  int  hold;
  int  ack_pct;
  int  rst_pm;
  int  n_wr;
  int  n_done;
  bit  saw_rst;
  logic [7:0] stream[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = P_IDLE;
    m_prev  = 1'b0;
    m_load  = 16'h0;
    m_end   = 16'h0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input bit act, input bit wr, input logic [24:0] addr,
                            input logic [7:0] data, input logic [4:0] idx, input bit ack);
    bit pop, full, push;
    int off;
    logic [15:0] wa;
    pop  = (m_q.size() > 0) && ack;
    full = (m_q.size() == DEPTH);
    push = 1'b0;
    wa   = 16'h0;
    case (m_phase)
      P_IDLE: if (act && !m_prev && idx == 5'd1) begin
        m_phase = P_HDR; m_err = 1'b0; m_load = 16'h0; m_end = 16'h0;
      end
      P_HDR: begin
        if (!act) begin
          m_err = 1'b1; m_phase = P_FIN;
        end else if (wr && addr == 25'd0) begin
          m_load[7:0] = data;
        end else if (wr && addr == 25'd1) begin
          m_load[15:8] = data; m_phase = P_DATA;
        end
      end
      P_DATA: begin
        if (wr) begin
          off = int'(addr) - 2;
          if (off < 0 || off > 65535 - int'(m_load)) m_err = 1'b1;
          else if (full && !pop) m_err = 1'b1;
          else begin push = 1'b1; wa = 16'(int'(m_load) + off); end
        end
        if (!act) m_phase = P_FLUSH;
      end
      P_FLUSH: if (m_q.size() == 0) m_phase = P_FIN;
      default: m_phase = P_IDLE;
    endcase
    if (pop) begin
      m_end = m_q[0][23:8] + 16'd1;
      void'(m_q.pop_front());
    end
    if (push) m_q.push_back({wa, data});
    m_prev = act;
  endtask

  // One clock: compare at negedge, drive new inputs, advance the model.
  task automatic cycle(input bit act, input bit wr, input logic [24:0] addr,
                       input logic [7:0] data, input logic [4:0] idx, input bit rstn);
    bit ack;
    bit r;
    logic [15:0] ea;
    logic [7:0]  ed;
    ea = (m_q.size() > 0) ? m_q[0][23:8] : 16'h0;
    ed = (m_q.size() > 0) ? m_q[0][7:0] : 8'h0;
    check_eq("ram_req", 32'(ram_req), 32'(m_q.size() > 0));
    check_eq("ram_addr", 32'(ram_addr), 32'(ea));
    check_eq("ram_data", 32'(ram_data), 32'(ed));
    check_eq("load_addr", 32'(load_addr), 32'(m_load));
    check_eq("end_addr", 32'(end_addr), 32'(m_end));
    check_eq("done", 32'(done), 32'(m_phase == P_FIN));
    check_eq("error", 32'(error), 32'(m_err));
    if (done === 1'b1) n_done++;
    if (hold > 0) begin ack = 1'b0; hold--; end
    else ack = ($urandom_range(99) < ack_pct);
    r = rstn && !($urandom_range(999) < rst_pm);
    if (!r) saw_rst = 1'b1;
    reset_n = r; dl_active = act; dl_wr = wr; dl_addr = addr;
    dl_data = data; dl_index = idx; ram_ack = ack;
    if (r && ram_req === 1'b1 && ack) n_wr++;
    if (!r) model_reset();
    else model_step(act, wr, addr, data, idx, ack);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic download(input logic [4:0] idx, input int gap, input int pct, input int hold_c);
    n_wr = 0; n_done = 0; saw_rst = 1'b0; ack_pct = pct;
    repeat (2) cycle(1'b0, 1'b0, 25'd0, 8'h0, idx, 1'b1);
    hold = hold_c;
    cycle(1'b1, 1'b0, 25'd0, 8'h0, idx, 1'b1);
    for (int i = 0; i < stream.size(); i++) begin
      cycle(1'b1, 1'b1, 25'(i), stream[i], idx, 1'b1);
      repeat ($urandom_range(gap)) cycle(1'b1, 1'b0, 25'd0, 8'h0, idx, 1'b1);
    end
    for (int k = 0; k < 300 && (k < 2 || m_phase != P_IDLE); k++)
      cycle(1'b0, 1'b0, 25'd0, 8'h0, idx, 1'b1);
    if (!saw_rst) check_eq("done_count", 32'(n_done), (idx == 5'd1) ? 32'd1 : 32'd0);
  endtask

  initial begin
    hold = 0; ack_pct = 100; rst_pm = 0;
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0;
    dl_data = '0; dl_index = '0; ram_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_eq("rst_req", 32'(ram_req), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);

    // basic load, ack always granted
    stream = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    download(5'd1, 0, 100, 0);
    check_eq("b_load", 32'(load_addr), 32'h1001);
    check_eq("b_end", 32'(end_addr), 32'h1004);
    check_eq("b_writes", 32'(n_wr), 32'd3);
    check_eq("b_error", 32'(error), 32'd0);

    // ack withheld while requests are pending
    download(5'd1, 0, 100, 14);
    check_eq("h_writes", 32'(n_wr), 32'd3);
    check_eq("h_error", 32'(error), 32'd0);

    // overflow: six back-to-back bytes, ack withheld
    stream = '{8'h00, 8'h20, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6};
    download(5'd1, 0, 100, 30);
    check_eq("o_writes", 32'(n_wr), 32'd4);
    check_eq("o_error", 32'(error), 32'd1);
    check_eq("o_end", 32'(end_addr), 32'h2004);

    // top of address space
    stream = '{8'hFF, 8'hFF, 8'h11, 8'h22};
    download(5'd1, 1, 100, 0);
    check_eq("t_writes", 32'(n_wr), 32'd1);
    check_eq("t_end", 32'(end_addr), 32'h0000);
    check_eq("t_error", 32'(error), 32'd1);

    // foreign index ignored, then normal load
    stream = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    download(5'd2, 0, 100, 0);
    check_eq("x_writes", 32'(n_wr), 32'd0);
    check_eq("x_error", 32'(error), 32'd1);
    download(5'd1, 0, 100, 0);
    check_eq("x2_writes", 32'(n_wr), 32'd3);
    check_eq("x2_error", 32'(error), 32'd0);

    // reset in the middle of a pending handshake
    ack_pct = 100;
    repeat (2) cycle(1'b0, 1'b0, 25'd0, 8'h0, 5'd1, 1'b1);
    hold = 50;
    cycle(1'b1, 1'b0, 25'd0, 8'h0, 5'd1, 1'b1);
    cycle(1'b1, 1'b1, 25'd0, 8'h00, 5'd1, 1'b1);
    cycle(1'b1, 1'b1, 25'd1, 8'h30, 5'd1, 1'b1);
    cycle(1'b1, 1'b1, 25'd2, 8'h5A, 5'd1, 1'b1);
    cycle(1'b1, 1'b1, 25'd3, 8'h5B, 5'd1, 1'b1);
    check_eq("r_req_before", 32'(ram_req), 32'd1);
    cycle(1'b1, 1'b0, 25'd0, 8'h0, 5'd1, 1'b0);
    check_eq("r_req_after", 32'(ram_req), 32'd0);
    check_eq("r_load_after", 32'(load_addr), 32'd0);
    hold = 0;
    download(5'd1, 0, 100, 0);
    check_eq("r_writes", 32'(n_wr), 32'd3);

    // randomized downloads, with occasional resets
    for (int t = 0; t < 40; t++) begin
      int n;
      stream.delete();
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
      if (n >= 2 && $urandom_range(99) < 30) stream[1] = 8'hFF;
      rst_pm = (t >= 30) ? 8 : 0;
      download(($urandom_range(99) < 80) ? 5'd1 : 5'(1 + $urandom_range(1, 30)),
               $urandom_range(3), $urandom_range(20, 100), $urandom_range(10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prg_loader.md
PRG_LOADER -- requirements
Module: prg_loader

Interface
REQ-001 Parameter PRG_INDEX, default 5'd1: menu index treated as a PRG download; any other index is ignored.
REQ-002 Parameter FIFO_DEPTH, default 4: byte buffer depth; must be a power of two, minimum 2.
REQ-003 clk  in  1  core clock; all logic on the rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 dl_active  in  1  download-in-progress level, already in the clk domain.
REQ-006 dl_wr  in  1  one-cycle byte strobe, clk domain.
REQ-007 dl_addr  in  25  byte offset within the file for the current strobe.
REQ-008 dl_data  in  8  byte value for the current strobe.
REQ-009 dl_index  in  5  menu index of the current download.
REQ-010 ram_req  out  1  RAM write request.
REQ-011 ram_ack  in  1  RAM arbiter grant; completes the presented write.
REQ-012 ram_addr  out  16  CPU-space write address.
REQ-013 ram_data  out  8  write data.
REQ-014 load_addr  out  16  load address taken from the PRG header.
REQ-015 end_addr  out  16  last written address + 1.
REQ-016 done  out  1  one-cycle pulse when the load completes.
REQ-017 error  out  1  sticky fault flag; cleared at the start of the next accepted download.

Function
REQ-018 FSM states: IDLE, HDR, DATA, FLUSH, FIN.
REQ-019 IDLE -> HDR on the rising edge of dl_active (registered previous value = 0, current = 1), only if dl_index == PRG_INDEX.
- Same transition clears error and zeroes load_addr and end_addr.
- With any other index the FSM stays IDLE and all strobes of that download are ignored.
REQ-020 Header bytes (HDR state):
- dl_wr with dl_addr == 0 sets load_addr[7:0].
- dl_wr with dl_addr == 1 sets load_addr[15:8] and moves the FSM to DATA.
REQ-021 DATA: each dl_wr pushes {load_addr + (dl_addr - 2) truncated to 16 bits, dl_data} into the FIFO.
- If dl_addr - 2 > 16'hFFFF - load_addr, the byte is dropped and error is set (no wrap to 0x0000).
REQ-022 A dl_wr that arrives while the FIFO is full, with no pop in the same cycle, drops the byte and sets error.
REQ-023 Simultaneous push and pop in one cycle are both performed; occupancy is unchanged; a full FIFO with a pop accepts the push.
REQ-024 ram_req is high whenever the FIFO is non-empty; ram_addr and ram_data come from the FIFO head.
REQ-025 ram_addr and ram_data must not change while ram_req = 1 and ram_ack = 0.
REQ-026 Cycle with ram_req = 1 and ram_ack = 1: head is popped and end_addr = written address + 1.
- Next entry, if present, is presented on the next cycle.
- One write per ack; ram_ack while ram_req = 0 is ignored.
REQ-027 Latency: a byte pushed at cycle N is presented on ram_addr/ram_data with ram_req = 1 at cycle N+1 at the earliest (FIFO previously empty).
REQ-028 dl_active falling in DATA -> FLUSH; dl_wr in FLUSH is ignored.
REQ-029 FLUSH -> FIN once the FIFO is empty and no request is outstanding.
REQ-030 FIN: done = 1 for exactly one cycle, then IDLE.
REQ-031 dl_active falling in HDR (fewer than 2 header bytes) sets error and goes to FIN; no RAM writes; load_addr keeps any partial value.
REQ-032 Outputs hold their values in IDLE until the next accepted download; a rising dl_active outside IDLE is ignored.

Reset
REQ-033 reset_n = 0 at a clock edge puts the FSM in IDLE, empties the FIFO, and clears all outputs to 0 on the next cycle.
- Applies mid-handshake: ram_req drops without waiting for ram_ack.
REQ-034 The registered dl_active history resets to 0, so a download already active when reset is released is accepted as a new rising edge.

Verification
REQ-035 Index 1, bytes 01 10 AA BB CC, ram_ack tied 1 -> writes 1001=AA, 1002=BB, 1003=CC in order; load_addr=1001, end_addr=1004; one done pulse; error=0.
REQ-036 Same stream, ram_ack held 0 for 10 cycles after the first request -> ram_addr stays 1001 with data AA throughout; all three bytes then written; no byte lost (FIFO_DEPTH=4).
REQ-037 Six data bytes strobed back-to-back, ram_ack held 0 -> first four buffered, last two dropped, error=1; after ack, exactly four writes, then done.
REQ-038 Header FF FF then bytes 11 22 -> one write FFFF=11; 22 dropped; error=1; end_addr=0000 (wraps as 16-bit +1).
REQ-039 Index 2 download -> no ram_req, no done, outputs unchanged; a following index-1 download loads normally.
REQ-040 reset_n pulsed low while ram_req=1 with 2 entries queued -> next cycle ram_req=0, outputs 0, FSM IDLE; a later download loads cleanly.
